// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared widths, rest code and player state encoding
package music_pkg;
    localparam int NOTE_W    = 4;
    localparam int OCT_W     = 2;
    localparam int ADDR_W    = 4;
    localparam int NUM_SLOTS = 16;
    localparam int TIMER_W   = 26;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        GAP,
        FINISH
    } state_t;
endpackage

// File: rtl/beat_timer.sv
// rtl/beat_timer.sv - loadable down-counter with expire flag for note and gap timing
module beat_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Loading N-1 makes the owning state last exactly N cycles.
    assign expired = (count == '0);
endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - sequences stored notes through a 2-cycle memory with beat and gap timing
module note_player
    import music_pkg::*;
#(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic [4:0]              note_count,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [NOTE_W+OCT_W-1:0] mem_q,
    output logic [NOTE_W-1:0]       note_out,
    output logic [OCT_W-1:0]        octave_out,
    output logic                    note_valid,
    output logic                    playing,
    output logic                    done
);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [TIMER_W-1:0] BEAT_LOAD = TIMER_W'(BEAT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = HAS_GAP ? TIMER_W'(GAP_CYCLES - 1) : '0;

    state_t               state;
    state_t               state_next;
    state_t               adv_state;
    logic [4:0]           eff_count;
    logic                 more;
    logic                 advance;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_expired;

    assign eff_count = (note_count > 5'd16) ? 5'd16 : note_count;
    assign more      = ({1'b0, mem_addr} + 5'd1) < eff_count;
    assign adv_state = (more || loop_en) ? FETCH : FINISH;

    beat_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = BEAT_LOAD;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (eff_count == 5'd0) ? FINISH : FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                state_next = PLAY;
                timer_load = 1'b1;
            end
            PLAY: begin
                if (timer_expired) begin
                    if (HAS_GAP) begin
                        state_next = GAP;
                        timer_load = 1'b1;
                        timer_val  = GAP_LOAD;
                    end else begin
                        advance    = 1'b1;
                        state_next = adv_state;
                    end
                end
            end
            GAP: begin
                if (timer_expired) begin
                    advance    = 1'b1;
                    state_next = adv_state;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // stop beats everything, including a start in the same cycle
        if (stop) begin
            state_next = IDLE;
            timer_load = 1'b0;
            advance    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= '0;
            note_out   <= '0;
            octave_out <= '0;
            note_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (stop) begin
                mem_addr   <= '0;
                note_valid <= 1'b0;
            end else begin
                if (state == IDLE && start) begin
                    mem_addr <= '0;
                end
                if (state == WAIT) begin
                    note_out   <= mem_q[NOTE_W-1:0];
                    octave_out <= mem_q[NOTE_W +: OCT_W];
                    note_valid <= (mem_q[NOTE_W-1:0] != NOTE_REST);
                end
                if (state == PLAY && timer_expired) begin
                    note_valid <= 1'b0;
                end
                if (advance && more) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end else if (advance && loop_en) begin
                    mem_addr <= '0;
                end
            end
        end
    end

    assign playing = (state != IDLE);
    assign done    = (state == FINISH);
endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - table-driven and directed checks of note_player with a 2-cycle memory model
module tb_note_player;
    localparam int BEAT = 4;
    localparam int GAPC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [4:0] note_count;
    logic [3:0] mem_addr;
    logic [5:0] mem_q;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic       note_valid;
    logic       playing;
    logic       done;

    logic [5:0] mem [16];

    always #5 clk = ~clk;

    // registered read of the registered address: data captured two edges after FETCH entry
    always @(posedge clk) mem_q <= mem[mem_addr];

    note_player #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .note_count (note_count),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .note_out   (note_out),
        .octave_out (octave_out),
        .note_valid (note_valid),
        .playing    (playing),
        .done       (done)
    );

    typedef struct {
        logic       start;
        logic       loop_en;
        logic [4:0] cnt;
        logic [3:0] addr;
        logic [3:0] note;
        logic [1:0] oct;
        logic       valid;
        logic       playing;
        logic       done;
    } vec_t;

    vec_t vq[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic st, input logic lp, input logic [4:0] cnt,
                        input logic [3:0] a, input logic [3:0] n, input logic [1:0] o,
                        input logic v, input logic p, input logic d);
        vec_t r;
        r.start = st; r.loop_en = lp; r.cnt = cnt; r.addr = a; r.note = n; r.oct = o;
        r.valid = v; r.playing = p; r.done = d;
        vq.push_back(r);
    endtask

    // FETCH, WAIT, BEAT play cycles, GAPC gap cycles for one stored note
    task automatic push_note(input logic lp, input logic [4:0] cnt, input logic [3:0] a,
                             input logic [3:0] pn, input logic [1:0] po, input logic [5:0] d);
        push(1'b0, lp, cnt, a, pn, po, 1'b0, 1'b1, 1'b0);
        push(1'b0, lp, cnt, a, pn, po, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < BEAT; i++)
            push(1'b0, lp, cnt, a, d[3:0], d[5:4], d[3:0] != 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < GAPC; i++)
            push(1'b0, lp, cnt, a, d[3:0], d[5:4], 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_table(input string tag);
        logic [12:0] act;
        logic [12:0] exp;
        for (int i = 0; i < vq.size(); i++) begin
            start      = vq[i].start;
            loop_en    = vq[i].loop_en;
            note_count = vq[i].cnt;
            stop       = 1'b0;
            step();
            act = {mem_addr, note_out, octave_out, note_valid, playing, done};
            exp = {vq[i].addr, vq[i].note, vq[i].oct, vq[i].valid, vq[i].playing, vq[i].done};
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("FAIL %s row %0d: got addr=%0h note=%0h oct=%0d valid=%b playing=%b done=%b expected addr=%0h note=%0h oct=%0d valid=%b playing=%b done=%b",
                         tag, i, act[12:9], act[8:5], act[4:3], act[2], act[1], act[0],
                         exp[12:9], exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
            end
        end
        start = 1'b0;
        vq.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        step();
        reset = 1'b0;
        check({tag, "_reset_outs"}, {19'd0, mem_addr, note_out, octave_out, note_valid, playing, done}, 32'd0);
    endtask

    task automatic load_three();
        for (int i = 0; i < 16; i++) mem[i] = 6'h00;
        mem[0] = 6'h13; mem[1] = 6'h25; mem[2] = 6'h3F;
    endtask

    initial begin
        logic [3:0] pn;
        logic [1:0] po;
        logic [5:0] d;
        logic [4:0] cnt;
        logic       saw_done;

        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; note_count = 5'd0;
        load_three();
        step();

        // three notes including a rest, no loop; start mid-play must be ignored
        do_reset("basic");
        pn = 4'h0; po = 2'd0;
        for (int i = 0; i < 3; i++) begin
            d = mem[i];
            push_note(1'b0, 5'd3, 4'(i), pn, po, d);
            pn = d[3:0]; po = d[5:4];
        end
        vq[0].start  = 1'b1;
        vq[12].start = 1'b1;
        push(1'b0, 1'b0, 5'd3, 4'd2, pn, po, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 5'd3, 4'd2, pn, po, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 5'd3, 4'd2, pn, po, 1'b0, 1'b0, 1'b0);
        run_table("basic");

        // empty song goes straight to FINISH
        do_reset("empty");
        push(1'b1, 1'b0, 5'd0, 4'd0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 5'd0, 4'd0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 5'd0, 4'd0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        run_table("empty");

        // looping over two notes, loop_en cleared during the last note 1
        do_reset("loop");
        pn = 4'h0; po = 2'd0;
        for (int i = 0; i < 4; i++) begin
            d = mem[i % 2];
            push_note(i != 3, 5'd2, 4'(i % 2), pn, po, d);
            pn = d[3:0]; po = d[5:4];
        end
        vq[0].start = 1'b1;
        push(1'b0, 1'b0, 5'd2, 4'd1, pn, po, 1'b0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 5'd2, 4'd1, pn, po, 1'b0, 1'b0, 1'b0);
        run_table("loop");

        // full memory, and an over-range count that must clamp to 16
        for (int i = 0; i < 16; i++) mem[i] = {2'(i % 4), 4'(i)};
        for (int k = 0; k < 2; k++) begin
            cnt = (k == 0) ? 5'd16 : 5'd20;
            do_reset("full");
            pn = 4'h0; po = 2'd0;
            for (int i = 0; i < 16; i++) begin
                d = mem[i];
                push_note(1'b0, cnt, 4'(i), pn, po, d);
                pn = d[3:0]; po = d[5:4];
            end
            vq[0].start = 1'b1;
            push(1'b0, 1'b0, cnt, 4'd15, pn, po, 1'b0, 1'b1, 1'b1);
            push(1'b0, 1'b0, cnt, 4'd15, pn, po, 1'b0, 1'b0, 1'b0);
            run_table((k == 0) ? "full16" : "full20");
        end

        // stop with simultaneous start on the second play cycle of note 2
        load_three();
        do_reset("stop");
        note_count = 5'd3; loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        check("stop_pre_note", {22'd0, mem_addr, note_out, note_valid, playing},
              {22'd0, 4'd1, 4'h5, 1'b1, 1'b1});
        stop = 1'b1; start = 1'b1;
        step();
        check("stop_idle", {26'd0, mem_addr, note_valid, playing},
              {26'd0, 4'd0, 1'b0, 1'b0});
        stop = 1'b0; start = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || playing) saw_done = 1'b1;
        end
        check("stop_no_done", {31'd0, saw_done}, 32'd0);

        // reset during the gap after note 1, then replay from address 0
        do_reset("rstgap");
        note_count = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("rstgap_in_gap", {25'd0, note_out, octave_out, note_valid},
              {25'd0, 4'h3, 2'd1, 1'b0});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstgap_outs", {19'd0, mem_addr, note_out, octave_out, note_valid, playing, done}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("rstgap_replay", {21'd0, mem_addr, note_out, octave_out, note_valid},
              {21'd0, 4'd0, 4'h3, 2'd1, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The module SHALL have parameter BEAT_CYCLES, default 12500000, giving clk cycles each stored note sounds (0.25 s at 50 MHz); legal range 1..2^26-1.
REQ-002 The module SHALL have parameter GAP_CYCLES, default 1250000, giving silent clk cycles between notes; 0 SHALL mean no gap.
REQ-003 Port: clk  in  1  system clock, all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  single-cycle request to begin playback at address 0.
REQ-006 Port: stop  in  1  abort playback.
REQ-007 Port: loop_en  in  1  when high, playback restarts at address 0 after the last note.
REQ-008 Port: note_count  in  5  number of valid stored notes, 0..16; values above 16 are treated as 16.
REQ-009 Port: mem_addr  out  4  registered read address to the 16x6 note memory.
REQ-010 Port: mem_q  in  6  memory read data, {octave[5:4], note[3:0]}.
REQ-011 Port: note_out  out  4  note code currently sounding.
REQ-012 Port: octave_out  out  2  octave currently sounding.
REQ-013 Port: note_valid  out  1  high while a non-rest note sounds.
REQ-014 Port: playing  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse when non-looping playback completes.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, WAIT, PLAY, GAP, FINISH.
REQ-017 In IDLE, start with stop low SHALL load mem_addr=0 and go to FETCH, or go to FINISH if effective note_count is 0.
REQ-018 FETCH and WAIT SHALL each last one cycle with mem_addr held, covering the memory's 2-cycle read latency.
REQ-019 On the WAIT->PLAY edge, mem_q SHALL be registered into note_out/octave_out; note_valid SHALL go high unless note code is 4'hF (rest).
REQ-020 PLAY SHALL last exactly BEAT_CYCLES cycles, timed by a down-counter loaded on entry.
REQ-021 On PLAY exit, note_valid SHALL drop; the next state SHALL be GAP if GAP_CYCLES>0, otherwise the advance decision of REQ-023.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles with note_valid low.
REQ-023 Advance: if mem_addr+1 < effective note_count, increment mem_addr and go to FETCH; else if loop_en, mem_addr SHALL wrap to 0 and go to FETCH; else go to FINISH.
REQ-024 mem_addr SHALL wrap 15->0 modulo 16; no other value beyond note_count-1 SHALL be read.
REQ-025 loop_en and note_count SHALL be sampled at each advance decision, not at start.
REQ-026 FINISH SHALL last one cycle, assert done, then return to IDLE.
REQ-027 stop high in any state SHALL force IDLE on the next edge with note_valid=0, mem_addr=0, and no done pulse; stop wins over simultaneous start.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 note_out and octave_out SHALL hold their last value in IDLE and GAP.

Reset
REQ-030 reset SHALL override all inputs and set state=IDLE, mem_addr=0, note_out=0, octave_out=0, note_valid=0, playing=0, done=0, counter=0 on the next edge.
REQ-031 reset asserted mid-note SHALL silence the output on that edge with no done pulse.

Structure
REQ-032 Package music_pkg SHALL hold NOTE_W=4, OCT_W=2, ADDR_W=4, NUM_SLOTS=16, NOTE_REST=4'hF, and the state encoding.
REQ-033 The duration counter SHALL be a sub-module beat_timer (26-bit loadable down-counter with expire flag) instantiated once and shared by PLAY and GAP.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2, memory model with 2-cycle latency)
REQ-034 Memory {0x13,0x25,0x3F}, note_count=3, loop_en=0, start pulse -> sequence note 3/oct1, note 5/oct2, rest with note_valid low, 4 cycles each, 2-cycle gaps; done pulses once; playing drops the cycle after done.
REQ-035 note_count=0, start -> FINISH next cycle, done pulse, note_valid never high, mem_addr stays 0.
REQ-036 note_count=2, loop_en=1 -> mem_addr sequence 0,1,0,1,...; clear loop_en during note 1 -> done after note 1 completes.
REQ-037 note_count=16 (and 20) -> all 16 addresses read in order, 15 followed by FINISH; 20 behaves identically to 16.
REQ-038 stop on the 2nd PLAY cycle of note 2 (with start asserted the same cycle) -> IDLE next edge, note_valid=0, mem_addr=0, no done.
REQ-039 reset high during GAP -> all outputs at reset values next edge; a later start plays from address 0 normally.
